pipeline_front_end: RTL
=======================

# pipeline_front_end

Front-end pipeline state holder for the 5-stage RV32I core: owns the PC register, the IF/ID register and the ID/EX control/rd slice. It consumes the stall controls (`PCWrite`, `IF_ID_Write`, `Hazard`) from the hazard detection unit and returns the `ID_EX_rd_idx` / `ID_EX_mem_read` / `ID_EX_reg_write` signals that unit compares against. It also sequences the ECALL-halt drain and counts stall cycles.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC value after reset.
- `NOP_INST`, 32'h0000_0013 (addi x0,x0,0): IF/ID instruction after reset.
- `CTRL_W`, 8: width of the ID control bundle. Bit 0 = mem_read, bit 1 = reg_write, other bits are pass-through.
- `DRAIN_CYCLES`, 3: bubble cycles after a halt request before `is_halted` asserts.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-low; state resets on a rising edge with `reset`=0.
- `PCWrite` in 1: 1 = PC may advance.
- `IF_ID_Write` in 1: 1 = IF/ID may load.
- `Hazard` in 1: 1 = insert a bubble into ID/EX.
- `imem_inst` in 32: instruction read combinationally at `pc`.
- `id_ctrl` in CTRL_W: decoded control of the instruction in ID.
- `id_rd_idx` in 5: rd field of the instruction in ID.
- `halt_req` in 1: ID holds an ECALL with x17==10 (resolved value).
- `pc` out 32: current PC and the imem address.
- `IF_ID_inst` out 32: registered instruction.
- `IF_ID_pc` out 32: registered PC.
- `IF_ID_valid` out 1: IF/ID holds a fetched instruction.
- `ID_EX_ctrl` out CTRL_W: registered control.
- `ID_EX_rd_idx` out 5: registered rd.
- `ID_EX_mem_read` out 1: equals `ID_EX_ctrl[0]`.
- `ID_EX_reg_write` out 1: equals `ID_EX_ctrl[1]`.
- `is_halted` out 1: core halted.
- `stall_count` out 32: saturating count of stall cycles.

## Operation
- Reset values:
  - `pc`=RESET_PC
  - `IF_ID_inst`=NOP_INST, `IF_ID_pc`=0, `IF_ID_valid`=0
  - `ID_EX_ctrl`=0, `ID_EX_rd_idx`=0
  - `is_halted`=0, `stall_count`=0
  - FSM=RUN, drain counter=0
- FSM states: RUN, DRAIN, HALTED.
- RUN behaviour:
  - PC: if `PCWrite`, `pc` <= `pc`+4 (mod 2^32, wraps from 32'hFFFF_FFFC to 0); else hold.
  - IF/ID: if `IF_ID_Write`, load `imem_inst`, `pc`, and `IF_ID_valid`=1; else hold all three.
  - ID/EX: if `Hazard`, load `ID_EX_ctrl`=0 and `ID_EX_rd_idx`=0 (bubble). Else load `id_ctrl` gated by `IF_ID_valid`: ctrl=0 when not valid. `ID_EX_rd_idx` loads `id_rd_idx` whenever `Hazard`=0.
  - The three stall inputs are honoured independently; no consistency is enforced between them.
  - `stall_count` increments by 1 on each cycle with `Hazard`=1 and saturates at 32'hFFFF_FFFF.
- Halt handling:
  - `halt_req` is accepted only in RUN with `Hazard`=0 and `IF_ID_valid`=1. On acceptance the ECALL's own `id_ctrl` is loaded into ID/EX normally, FSM goes to DRAIN, and the counter is loaded with DRAIN_CYCLES.
  - If `halt_req` and `Hazard` are both 1, `Hazard` wins: a bubble is inserted, the request is ignored, and it is re-sampled next cycle.
  - DRAIN: `pc` and IF/ID frozen regardless of `PCWrite`/`IF_ID_Write`; ID/EX loaded with a bubble every cycle; `stall_count` unchanged. The counter decrements by 1 per cycle; on the cycle it decrements from 1 to 0, FSM goes to HALTED.
  - HALTED: `is_halted`=1 (registered, first high the cycle FSM enters HALTED); all state frozen, ID/EX holds its bubble; exits only on reset.
- Reset has priority over every other input, including mid-DRAIN and in HALTED.

## Timing
- All outputs are registered; none has a combinational input-to-output path.
- `pc` advances one cycle after the edge sampling `PCWrite`=1.
- Fetch-to-IF/ID latency: 1 cycle.
- Load-use stall: one `Hazard` cycle yields exactly one ID/EX bubble, and the IF/ID contents re-present next cycle.
- Halt: the request is accepted on edge N. With DRAIN_CYCLES=3, the FSM is in DRAIN after N, N+1 and N+2, enters HALTED on edge N+3, and `is_halted` is first 1 after edge N+3.

## Test plan
- **Reset:** hold `reset`=0 for 2 cycles with random inputs, then release. Required: `pc`=0, `IF_ID_inst`=32'h13, `IF_ID_valid`=0, `ID_EX_ctrl`=0, `stall_count`=0. First release edge: `pc`=4, `IF_ID_pc`=0, `IF_ID_valid`=1.
- **Load-use stall:** ID holds lw x5, `Hazard`/`PCWrite`/`IF_ID_Write`=1/0/0 for 1 cycle. Required: `pc` and `IF_ID_inst` unchanged, `ID_EX_ctrl`=0, `ID_EX_rd_idx`=0, `stall_count`=1. Next cycle: normal advance.
- **Saturation/wrap:** force `stall_count` to 32'hFFFF_FFFE, then assert `Hazard` 3 cycles. Required: `stall_count` ends at 32'hFFFF_FFFF. Separately, `pc`=32'hFFFF_FFFC with `PCWrite`=1 gives `pc`=0.
- **Halt drain:** `halt_req`=1, `Hazard`=0. Required: 3 bubble cycles with `pc` frozen, then `is_halted`=1 permanently while `PCWrite`=1 toggles.
- **Halt vs hazard:** `halt_req`=1 with `Hazard`=1 for 2 cycles, then `Hazard`=0. Required: FSM enters DRAIN only after the third edge; `stall_count`=2.
- **Reset mid-drain:** assert `reset`=0 during the second DRAIN cycle. Required: FSM=RUN, `pc`=RESET_PC, `is_halted`=0 after that edge.

Source files
------------

// File: rtl/pipeline_front_end.sv
// Front-end pipeline state for the 5-stage RV32I core: PC, IF/ID, ID/EX control/rd slice,
// ECALL-halt drain sequencing and a saturating stall-cycle counter.
module pipeline_front_end #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] NOP_INST     = 32'h0000_0013,
  parameter int unsigned CTRL_W       = 8,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PCWrite,
  input  logic              IF_ID_Write,
  input  logic              Hazard,
  input  logic [31:0]       imem_inst,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [4:0]        id_rd_idx,
  input  logic              halt_req,
  output logic [31:0]       pc,
  output logic [31:0]       IF_ID_inst,
  output logic [31:0]       IF_ID_pc,
  output logic              IF_ID_valid,
  output logic [CTRL_W-1:0] ID_EX_ctrl,
  output logic [4:0]        ID_EX_rd_idx,
  output logic              ID_EX_mem_read,
  output logic              ID_EX_reg_write,
  output logic              is_halted,
  output logic [31:0]       stall_count
);

  localparam int unsigned DCNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [DCNT_W-1:0] DRAIN_INIT = DCNT_W'(DRAIN_CYCLES);
  localparam logic [DCNT_W-1:0] DCNT_ONE   = DCNT_W'(1);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       if_id_inst_q, if_id_inst_d;
  logic [31:0]       if_id_pc_q, if_id_pc_d;
  logic              if_id_valid_q, if_id_valid_d;
  logic [CTRL_W-1:0] id_ex_ctrl_q, id_ex_ctrl_d;
  logic [4:0]        id_ex_rd_q, id_ex_rd_d;
  logic              halted_q, halted_d;
  logic [31:0]       stall_cnt_q, stall_cnt_d;
  logic              halt_accept;

  // Hazard beats a pending halt: the request is simply re-sampled next cycle.
  assign halt_accept = halt_req && !Hazard && if_id_valid_q;

  always_comb begin
    state_d       = state_q;
    dcnt_d        = dcnt_q;
    pc_d          = pc_q;
    if_id_inst_d  = if_id_inst_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_valid_d = if_id_valid_q;
    id_ex_ctrl_d  = id_ex_ctrl_q;
    id_ex_rd_d    = id_ex_rd_q;
    halted_d      = halted_q;
    stall_cnt_d   = stall_cnt_q;

    case (state_q)
      ST_RUN: begin
        if (PCWrite) begin
          pc_d = pc_q + 32'd4;
        end
        if (IF_ID_Write) begin
          if_id_inst_d  = imem_inst;
          if_id_pc_d    = pc_q;
          if_id_valid_d = 1'b1;
        end
        if (Hazard) begin
          id_ex_ctrl_d = '0;
          id_ex_rd_d   = '0;
          if (stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
          end
        end else begin
          id_ex_ctrl_d = if_id_valid_q ? id_ctrl : '0;
          id_ex_rd_d   = id_rd_idx;
          if (halt_accept) begin
            if (DRAIN_CYCLES == 0) begin
              state_d  = ST_HALTED;
              halted_d = 1'b1;
            end else begin
              state_d = ST_DRAIN;
              dcnt_d  = DRAIN_INIT;
            end
          end
        end
      end

      ST_DRAIN: begin
        id_ex_ctrl_d = '0;
        id_ex_rd_d   = '0;
        dcnt_d       = dcnt_q - DCNT_ONE;
        if (dcnt_q == DCNT_ONE) begin
          state_d  = ST_HALTED;
          halted_d = 1'b1;
        end
      end

      ST_HALTED: begin
        id_ex_ctrl_d = '0;
        id_ex_rd_d   = '0;
      end

      default: begin
        state_d = ST_RUN;
        dcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_RUN;
      dcnt_q        <= '0;
      pc_q          <= RESET_PC;
      if_id_inst_q  <= NOP_INST;
      if_id_pc_q    <= '0;
      if_id_valid_q <= 1'b0;
      id_ex_ctrl_q  <= '0;
      id_ex_rd_q    <= '0;
      halted_q      <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      dcnt_q        <= dcnt_d;
      pc_q          <= pc_d;
      if_id_inst_q  <= if_id_inst_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_valid_q <= if_id_valid_d;
      id_ex_ctrl_q  <= id_ex_ctrl_d;
      id_ex_rd_q    <= id_ex_rd_d;
      halted_q      <= halted_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign pc              = pc_q;
  assign IF_ID_inst      = if_id_inst_q;
  assign IF_ID_pc        = if_id_pc_q;
  assign IF_ID_valid     = if_id_valid_q;
  assign ID_EX_ctrl      = id_ex_ctrl_q;
  assign ID_EX_rd_idx    = id_ex_rd_q;
  assign ID_EX_mem_read  = id_ex_ctrl_q[0];
  assign ID_EX_reg_write = id_ex_ctrl_q[1];
  assign is_halted       = halted_q;
  assign stall_count     = stall_cnt_q;

endmodule
